// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs mult/div with a fixed busy
// latency, and serves mfhi/mflo/mthi/mtlo.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        res,
  input  logic [3:0]  E_MDU_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        E_MDU_start,
  output logic        E_MDU_busy,
  output logic [31:0] E_MDU_out,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return 32'h0000_0000 - v;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

  logic [31:0]      hi_r, lo_r, temp_hi_r, temp_lo_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r, div_zero_r;

  logic [31:0]      hi_n_s, lo_n_s, temp_hi_n_s, temp_lo_n_s;
  logic [CNT_W-1:0] cnt_n_s;
  logic             busy_n_s, div_zero_n_s;

  logic [63:0] a_ext_s, b_ext_s, prod_s;
  logic        signed_div_s;
  logic [31:0] num_s, den_s, quo_mag_s, rem_mag_s, quo_s, rem_s;

  // Operand extension and the shared 64-bit multiplier; the low 64 bits of
  // the product are sign-correct once operands are extended appropriately.
  always_comb begin
    if (E_MDU_op == OP_MULT) begin
      a_ext_s = {{32{E_A[31]}}, E_A};
      b_ext_s = {{32{E_B[31]}}, E_B};
    end else begin
      a_ext_s = {32'h0000_0000, E_A};
      b_ext_s = {32'h0000_0000, E_B};
    end
    prod_s = a_ext_s * b_ext_s;
  end

  // Single unsigned divider on magnitudes; a zero divisor is replaced by one
  // so the datapath never produces X (the result is discarded anyway).
  always_comb begin
    signed_div_s = (E_MDU_op == OP_DIV);
    if (signed_div_s) begin
      num_s = abs32(E_A);
      den_s = abs32(E_B);
    end else begin
      num_s = E_A;
      den_s = E_B;
    end
    if (E_B == 32'h0000_0000) begin
      den_s = 32'h0000_0001;
    end else begin
      den_s = den_s;
    end
    quo_mag_s = num_s / den_s;
    rem_mag_s = num_s % den_s;
    quo_s = (signed_div_s && (E_A[31] ^ E_B[31])) ? neg32(quo_mag_s) : quo_mag_s;
    rem_s = (signed_div_s && E_A[31]) ? neg32(rem_mag_s) : rem_mag_s;
  end

  // Next-state: accept work only when idle, otherwise count down and retire.
  always_comb begin
    hi_n_s       = hi_r;
    lo_n_s       = lo_r;
    temp_hi_n_s  = temp_hi_r;
    temp_lo_n_s  = temp_lo_r;
    cnt_n_s      = cnt_r;
    div_zero_n_s = div_zero_r;
    if (!busy_r) begin
      case (E_MDU_op)
        OP_MULT, OP_MULTU: begin
          temp_hi_n_s  = prod_s[63:32];
          temp_lo_n_s  = prod_s[31:0];
          cnt_n_s      = MULT_LOAD;
          div_zero_n_s = 1'b0;
        end
        OP_DIV, OP_DIVU: begin
          temp_hi_n_s  = rem_s;
          temp_lo_n_s  = quo_s;
          cnt_n_s      = DIV_LOAD;
          div_zero_n_s = (E_B == 32'h0000_0000);
        end
        OP_MTHI: hi_n_s = E_A;
        OP_MTLO: lo_n_s = E_A;
        default: begin
          cnt_n_s = cnt_r;
        end
      endcase
    end else if (cnt_r == CNT_ONE) begin
      cnt_n_s = CNT_ZERO;
      if (!div_zero_r) begin
        hi_n_s = temp_hi_r;
        lo_n_s = temp_lo_r;
      end else begin
        hi_n_s = hi_r;
        lo_n_s = lo_r;
      end
    end else begin
      cnt_n_s = cnt_r - CNT_ONE;
    end
    busy_n_s = (cnt_n_s != CNT_ZERO);
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      hi_r       <= 32'h0000_0000;
      lo_r       <= 32'h0000_0000;
      temp_hi_r  <= 32'h0000_0000;
      temp_lo_r  <= 32'h0000_0000;
      cnt_r      <= CNT_ZERO;
      busy_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      hi_r       <= hi_n_s;
      lo_r       <= lo_n_s;
      temp_hi_r  <= temp_hi_n_s;
      temp_lo_r  <= temp_lo_n_s;
      cnt_r      <= cnt_n_s;
      busy_r     <= busy_n_s;
      div_zero_r <= div_zero_n_s;
    end
  end

  // Hazard-unit start flag and the mfhi/mflo read port.
  always_comb begin
    E_MDU_start = (E_MDU_op >= OP_MULT) && (E_MDU_op <= OP_DIVU);
    case (E_MDU_op)
      OP_MFHI: E_MDU_out = hi_r;
      OP_MFLO: E_MDU_out = lo_r;
      default: E_MDU_out = 32'h0000_0000;
    endcase
  end

  assign E_MDU_busy = busy_r;
  assign E_HI       = hi_r;
  assign E_LO       = lo_r;

endmodule
